// File: rtl/idu_cp0_iq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idu_cp0_iq_pkg
// Description : Shared IDU definitions for the CP0 issue queue: field widths,
//               the ENV major opcode, ENV function flags and the entry payload
//               record held by each queue slot.
// Revision    : 1.0 - initial release
// ============================================================================
package idu_cp0_iq_pkg;

    localparam int IID_W = 5;
    localparam int OPC_W = 7;
    localparam int XLEN  = 64;

    // SYSTEM major opcode (ENV / CSR class)
    localparam logic [OPC_W-1:0] I_ENV = 7'b1110011;

    // ENV function encodings carried in the immediate field
    localparam logic [2:0] ENVFLAG_ECALL  = 3'd0;
    localparam logic [2:0] ENVFLAG_EBREAK = 3'd1;
    localparam logic [2:0] ENVFLAG_MRET   = 3'd2;
    localparam logic [2:0] ENVFLAG_SRET   = 3'd3;
    localparam logic [2:0] ENVFLAG_WFI    = 3'd4;

    // Per-entry payload. Valid, readiness and the source tag live beside it in
    // the entry because the tag width is a per-instance parameter.
    typedef struct packed {
        logic [IID_W-1:0] iid;
        logic [OPC_W-1:0] opcode;
        logic             psrc1_vld;
        logic [XLEN-1:0]  value;
        logic             imm_vld;
        logic [XLEN-1:0]  imm;
    } cp0_iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/idu_cp0_iq_entry.sv
`default_nettype none
// ============================================================================
// Module      : idu_cp0_iq_entry
// Description : One CP0 issue-queue slot. Holds the payload, snoops the
//               writeback bus to capture its source operand, and reports
//               whether it may issue.
// Ports       : clk/rst_clk       - clock, synchronous active-high reset
//               i_clear           - global flush, drops the entry
//               i_wr_en/i_wr_*    - dispatch write into this slot
//               i_pop             - entry issued this cycle
//               i_wb_*            - writeback broadcast
//               o_vld/o_ready     - occupancy and operand readiness
//               o_data            - stored payload
// Revision    : 1.0 - initial release
// ============================================================================
module idu_cp0_iq_entry
    import idu_cp0_iq_pkg::*;
#(
    parameter int PREG_W = 6
) (
    input  logic                clk,
    input  logic                rst_clk,
    input  logic                i_clear,
    input  logic                i_wr_en,
    input  cp0_iq_entry_t       i_wr_data,
    input  logic                i_wr_rdy,
    input  logic [PREG_W-1:0]   i_wr_preg,
    input  logic                i_pop,
    input  logic                i_wb_vld,
    input  logic [PREG_W-1:0]   i_wb_preg,
    input  logic [XLEN-1:0]     i_wb_value,
    output logic                o_vld,
    output logic                o_ready,
    output cp0_iq_entry_t       o_data
);

    logic                r_vld;
    logic                r_rdy;
    logic [PREG_W-1:0]   r_preg;
    cp0_iq_entry_t       r_data;

    logic                w_wb_hit;
    logic                w_byp_hit;

    // Wakeup of an already-queued entry waiting on this tag
    assign w_wb_hit  = i_wb_vld & r_vld & r_data.psrc1_vld & ~r_rdy
                     & (r_preg == i_wb_preg);
    // Writeback arriving in the same cycle as dispatch of a waiting operand
    assign w_byp_hit = i_wb_vld & i_wr_data.psrc1_vld & ~i_wr_rdy
                     & (i_wr_preg == i_wb_preg);

    always_ff @(posedge clk) begin
        if (rst_clk || i_clear) begin
            r_vld <= 1'b0;
        end else if (i_wr_en) begin
            r_vld <= 1'b1;
        end else if (i_pop) begin
            r_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_clk) begin
            r_data <= '0;
            r_rdy  <= 1'b0;
            r_preg <= '0;
        end else if (i_wr_en) begin
            r_data <= i_wr_data;
            r_rdy  <= i_wr_rdy | w_byp_hit;
            r_preg <= i_wr_preg;
            if (w_byp_hit) begin
                r_data.value <= i_wb_value;
            end
        end else if (w_wb_hit) begin
            r_rdy        <= 1'b1;
            r_data.value <= i_wb_value;
        end
    end

    assign o_vld   = r_vld;
    assign o_ready = ~r_data.psrc1_vld | r_rdy;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/idu_cp0_iq.sv
`default_nettype none
// ============================================================================
// Module      : idu_cp0_iq
// Description : In-order issue queue for CP0/system instructions. Entries wait
//               for their single source operand (captured from writeback) and
//               the oldest issues only once ready; younger entries never pass it.
// Ports       : clk/rst_clk           - clock, synchronous active-high reset
//               rtu_global_flush      - empties the queue
//               idu_cp0_iq_dis_*      - dispatch interface
//               cp0_iq_idu_full       - queue full, dispatch refused
//               exu_iq_wb_*           - writeback broadcast for wakeup
//               idu_exu_cp0_*         - issue interface (no back-pressure)
// Revision    : 1.0 - initial release
// ============================================================================
module idu_cp0_iq
    import idu_cp0_iq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 6
) (
    input  logic                clk,
    input  logic                rst_clk,
    input  logic                rtu_global_flush,
    input  logic                idu_cp0_iq_dis_vld,
    input  logic [IID_W-1:0]    idu_cp0_iq_dis_iid,
    input  logic [OPC_W-1:0]    idu_cp0_iq_dis_opcode,
    input  logic                idu_cp0_iq_dis_psrc1_vld,
    input  logic [PREG_W-1:0]   idu_cp0_iq_dis_psrc1_preg,
    input  logic                idu_cp0_iq_dis_psrc1_rdy,
    input  logic [XLEN-1:0]     idu_cp0_iq_dis_psrc1_value,
    input  logic                idu_cp0_iq_dis_imm_vld,
    input  logic [XLEN-1:0]     idu_cp0_iq_dis_imm,
    output logic                cp0_iq_idu_full,
    input  logic                exu_iq_wb_vld,
    input  logic [PREG_W-1:0]   exu_iq_wb_preg,
    input  logic [XLEN-1:0]     exu_iq_wb_value,
    output logic                idu_exu_cp0_vld,
    output logic [IID_W-1:0]    idu_exu_cp0_iid,
    output logic [OPC_W-1:0]    idu_exu_cp0_opcode,
    output logic                idu_exu_cp0_psrc1_vld,
    output logic [XLEN-1:0]     idu_exu_cp0_psrc1_value,
    output logic                idu_exu_cp0_imm_vld,
    output logic [XLEN-1:0]     idu_exu_cp0_imm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_dis_acc;
    logic               w_issue;
    cp0_iq_entry_t      w_dis_data;
    cp0_iq_entry_t      w_head;
    cp0_iq_entry_t      w_ent_data [DEPTH];
    logic [DEPTH-1:0]   w_ent_vld;
    logic [DEPTH-1:0]   w_ent_rdy;

    // Full looks only at the current count, so a pop in the same cycle does
    // not open a slot for dispatch until the next cycle.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_dis_acc = idu_cp0_iq_dis_vld & ~w_full & ~rtu_global_flush;
    assign w_head    = w_ent_data[r_head];
    assign w_issue   = w_ent_vld[r_head] & w_ent_rdy[r_head] & ~rtu_global_flush;

    always_comb begin
        w_dis_data           = '0;
        w_dis_data.iid       = idu_cp0_iq_dis_iid;
        w_dis_data.opcode    = idu_cp0_iq_dis_opcode;
        w_dis_data.psrc1_vld = idu_cp0_iq_dis_psrc1_vld;
        w_dis_data.value     = idu_cp0_iq_dis_psrc1_value;
        w_dis_data.imm_vld   = idu_cp0_iq_dis_imm_vld;
        w_dis_data.imm       = idu_cp0_iq_dis_imm;
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            idu_cp0_iq_entry #(
                .PREG_W (PREG_W)
            ) u_entry (
                .clk        (clk),
                .rst_clk    (rst_clk),
                .i_clear    (rtu_global_flush),
                .i_wr_en    (w_dis_acc & (r_tail == PTR_W'(i))),
                .i_wr_data  (w_dis_data),
                .i_wr_rdy   (idu_cp0_iq_dis_psrc1_rdy),
                .i_wr_preg  (idu_cp0_iq_dis_psrc1_preg),
                .i_pop      (w_issue & (r_head == PTR_W'(i))),
                .i_wb_vld   (exu_iq_wb_vld),
                .i_wb_preg  (exu_iq_wb_preg),
                .i_wb_value (exu_iq_wb_value),
                .o_vld      (w_ent_vld[i]),
                .o_ready    (w_ent_rdy[i]),
                .o_data     (w_ent_data[i])
            );
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst_clk || rtu_global_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_dis_acc) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_issue) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_dis_acc) - CNT_W'(w_issue);
        end
    end

    assign cp0_iq_idu_full = w_full;

    // Issue fields are zeroed whenever nothing issues
    always_comb begin
        idu_exu_cp0_vld         = w_issue;
        idu_exu_cp0_iid         = '0;
        idu_exu_cp0_opcode      = '0;
        idu_exu_cp0_psrc1_vld   = 1'b0;
        idu_exu_cp0_psrc1_value = '0;
        idu_exu_cp0_imm_vld     = 1'b0;
        idu_exu_cp0_imm         = '0;
        if (w_issue) begin
            idu_exu_cp0_iid         = w_head.iid;
            idu_exu_cp0_opcode      = w_head.opcode;
            idu_exu_cp0_psrc1_vld   = w_head.psrc1_vld;
            idu_exu_cp0_psrc1_value = w_head.value;
            idu_exu_cp0_imm_vld     = w_head.imm_vld;
            idu_exu_cp0_imm         = w_head.imm;
        end
    end

endmodule
`default_nettype wire
